mxv_sequencer: RTL and testbench

MXV_SEQUENCER -- requirements
Module: mxv_sequencer

---
 rtl/mxv_pkg.sv | 28 ++
 rtl/mxv_if.sv | 38 +++
 rtl/mxv_index_counter.sv | 29 ++
 rtl/mxv_sequencer.sv | 108 ++++++++++
 tb/tb_mxv_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mxv_pkg.sv
// Shared types and helpers for the matrix-vector sequencer.
package mxv_pkg;

    localparam int MAX_SIZE_DEFAULT = 8;
    localparam int DATA_W_DEFAULT   = 8;
    localparam int SIZE_W           = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        LOAD_ROW,
        PUSH,
        FINISH
    } state_t;

    // Width needed to index 0..value-1; never less than one bit.
    function automatic int CeilLog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mxv_if.sv
// Handshake and datapath-control bundle between a host/datapath and the sequencer.
interface mxv_if #(
    parameter int MAX_SIZE = mxv_pkg::MAX_SIZE_DEFAULT,
    parameter int DATA_W   = mxv_pkg::DATA_W_DEFAULT
) ();
    localparam int IDX_W = mxv_pkg::CeilLog2(MAX_SIZE);

    logic                        start;
    logic [mxv_pkg::SIZE_W-1:0]  matrix_size;
    logic                        abort;
    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic                        in_ready;
    logic                        vec_we;
    logic [IDX_W-1:0]            vec_idx;
    logic                        mac_en;
    logic                        mac_clear;
    logic [IDX_W-1:0]            col_idx;
    logic                        result_push;
    logic [IDX_W-1:0]            row_idx;
    logic                        busy;
    logic                        done;
    logic                        size_err;

    // Host / datapath side.
    modport master (
        output start, matrix_size, abort, in_valid, in_data,
        input  in_ready, vec_we, vec_idx, mac_en, mac_clear, col_idx,
               result_push, row_idx, busy, done, size_err
    );

    // Sequencer side.
    modport slave (
        input  start, matrix_size, abort, in_valid, in_data,
        output in_ready, vec_we, vec_idx, mac_en, mac_clear, col_idx,
               result_push, row_idx, busy, done, size_err
    );
endinterface

// File: rtl/mxv_index_counter.sv
// Index counter that runs 0..term and wraps back to 0 after the terminal value.
module mxv_index_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         last
);
    logic [W-1:0] count_q;

    assign count = count_q;
    assign last  = (count_q == term);

    // Clear has priority; otherwise advance on enable, wrapping at the terminal value.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= last ? '0 : count_q + 1'b1;
        end
    end
endmodule

// File: rtl/mxv_sequencer.sv
// Control sequencer for an N x N matrix times N vector operation streamed row-major.
module mxv_sequencer
    import mxv_pkg::*;
#(
    parameter int MAX_SIZE = MAX_SIZE_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    mxv_if.slave  bus
);
    localparam int IDX_W = CeilLog2(MAX_SIZE);
    localparam logic [SIZE_W-1:0] MAX_SIZE_V = SIZE_W'(MAX_SIZE);

    if ($bits(bus.in_data) != DATA_W || $bits(bus.vec_idx) != IDX_W) begin : g_width_check
        $error("mxv_sequencer: interface parameters do not match the sequencer");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_last_q;     // N-1, the terminal value for both counters
    logic             size_err_q;

    logic             size_ok;
    logic             start_ok;
    logic             start_bad;
    logic             loading;
    logic             xfer;
    logic [IDX_W-1:0] elem_count;
    logic             elem_last;
    logic [IDX_W-1:0] row_count;
    logic             row_last;
    logic             cnt_clr;

    assign size_ok   = (bus.matrix_size != '0) && (bus.matrix_size <= MAX_SIZE_V);
    assign start_ok  = (state_q == IDLE) && bus.start && !bus.abort && size_ok;
    assign start_bad = (state_q == IDLE) && bus.start && !bus.abort && !size_ok;

    // Abort blocks the handshake so an element offered in the abort cycle is not consumed.
    assign loading  = (state_q == LOAD_VEC) || (state_q == LOAD_ROW);
    assign xfer     = bus.in_valid && loading && !bus.abort;
    assign cnt_clr  = bus.abort || start_ok;

    // Element counter: vector index in LOAD_VEC, then column index in LOAD_ROW.
    mxv_index_counter #(.W(IDX_W)) u_elem_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .clr   (cnt_clr),
        .term  (n_last_q),
        .count (elem_count),
        .last  (elem_last)
    );

    // Row counter advances once per result push.
    mxv_index_counter #(.W(IDX_W)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == PUSH),
        .clr   (cnt_clr),
        .term  (n_last_q),
        .count (row_count),
        .last  (row_last)
    );

    // State, captured size and the registered size-error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_last_q   <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_err_q <= start_bad;
            if (start_ok) begin
                n_last_q <= IDX_W'(bus.matrix_size - 8'd1);
            end
        end
    end

    // Next-state decode; abort returns to IDLE from anywhere.
    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_ok)              state_d = LOAD_VEC;
            LOAD_VEC: if (xfer && elem_last)     state_d = LOAD_ROW;
            LOAD_ROW: if (xfer && elem_last)     state_d = PUSH;
            PUSH:     state_d = row_last ? FINISH : LOAD_ROW;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d = IDLE;
        end
    end

    assign bus.in_ready    = loading && !bus.abort;
    assign bus.vec_we      = xfer && (state_q == LOAD_VEC);
    assign bus.mac_en      = xfer && (state_q == LOAD_ROW);
    assign bus.mac_clear   = bus.mac_en && (elem_count == '0);
    assign bus.vec_idx     = elem_count;
    assign bus.col_idx     = elem_count;
    assign bus.row_idx     = row_count;
    assign bus.result_push = (state_q == PUSH);
    assign bus.done        = (state_q == FINISH);
    assign bus.busy        = (state_q != IDLE);
    assign bus.size_err    = size_err_q;
endmodule

// File: tb/tb_mxv_sequencer.sv
// Self-checking bench: transaction-level model plus a datapath fed by the sequencer.
module tb_mxv_sequencer;
    localparam int MAX_N = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mxv_if #(.MAX_SIZE(MAX_N), .DATA_W(8)) tif ();

    mxv_sequencer #(.MAX_SIZE(MAX_N), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    bit m_active, m_push_pend, m_fin_pend, m_err_pend;
    int m_n, m_k, m_pushes;

    // ---------------- datapath + monitors ----------------
    int vec_mem [MAX_N];
    int acc;
    int res_q[$];
    int mon_xfers, mon_pushes, mon_dones, mon_errs;
    int cyc, last_push_cyc, last_done_cyc;

    task automatic model_clear();
        m_active = 0; m_push_pend = 0; m_fin_pend = 0; m_err_pend = 0;
        m_n = 0; m_k = 0; m_pushes = 0;
    endtask

    task automatic model_step();
        bit err;
        err = 0;
        if (tif.abort) begin
            m_active = 0; m_push_pend = 0; m_fin_pend = 0; m_k = 0; m_pushes = 0;
        end else if (!m_active) begin
            if (tif.start) begin
                if (tif.matrix_size >= 1 && tif.matrix_size <= MAX_N) begin
                    m_active = 1; m_n = int'(tif.matrix_size); m_k = 0; m_pushes = 0;
                end else begin
                    err = 1;
                end
            end
        end else if (m_fin_pend) begin
            m_active = 0; m_fin_pend = 0;
        end else if (m_push_pend) begin
            m_push_pend = 0;
            m_pushes++;
            if (m_pushes == m_n) m_fin_pend = 1;
        end else if (tif.in_valid) begin
            m_k++;
            if (m_k > m_n && (m_k - m_n) % m_n == 0) m_push_pend = 1;
        end
        m_err_pend = err;
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    always begin
        @(negedge clk);
        if (!reset) begin
            model_clear();
            check("rst_in_ready", 32'(tif.in_ready), 0);
            check("rst_busy", 32'(tif.busy), 0);
            check("rst_push", 32'(tif.result_push), 0);
            check("rst_done", 32'(tif.done), 0);
            check("rst_size_err", 32'(tif.size_err), 0);
            check("rst_row_idx", 32'(tif.row_idx), 0);
            check("rst_vec_idx", 32'(tif.vec_idx), 0);
        end else begin
            bit loading, e_ready, e_xfer, in_vec, e_vec_we, e_mac, e_clr;
            int col;
            loading  = m_active && !m_push_pend && !m_fin_pend;
            e_ready  = loading && !tif.abort;
            e_xfer   = e_ready && tif.in_valid;
            in_vec   = m_k < m_n;
            e_vec_we = e_xfer && in_vec;
            e_mac    = e_xfer && !in_vec;
            col      = 0;
            if (m_active && !in_vec) col = (m_k - m_n) % m_n;
            e_clr    = e_mac && (col == 0);
            check("in_ready", 32'(tif.in_ready), 32'(e_ready));
            check("vec_we", 32'(tif.vec_we), 32'(e_vec_we));
            check("mac_en", 32'(tif.mac_en), 32'(e_mac));
            check("mac_clear", 32'(tif.mac_clear), 32'(e_clr));
            check("result_push", 32'(tif.result_push), 32'(m_push_pend));
            check("done", 32'(tif.done), 32'(m_fin_pend));
            check("busy", 32'(tif.busy), 32'(m_active));
            check("size_err", 32'(tif.size_err), 32'(m_err_pend));
            if (e_vec_we) check("vec_idx", 32'(tif.vec_idx), 32'(m_k));
            if (e_mac)    check("col_idx", 32'(tif.col_idx), 32'(col));
            if (m_push_pend) check("row_idx", 32'(tif.row_idx), 32'(m_pushes));

            // Datapath driven purely by the sequencer's outputs.
            if (tif.vec_we) vec_mem[tif.vec_idx] = int'(tif.in_data);
            if (tif.mac_en) acc = (tif.mac_clear ? 0 : acc) + int'(tif.in_data) * vec_mem[tif.col_idx];
            if (tif.result_push) begin
                res_q.push_back(acc);
                mon_pushes++;
                last_push_cyc = cyc;
            end
            if (tif.vec_we || tif.mac_en) mon_xfers++;
            if (tif.done) begin
                mon_dones++;
                last_done_cyc = cyc;
            end
            if (tif.size_err) mon_errs++;
        end
        @(posedge clk);
        cyc++;
        if (reset) model_step();
        else model_clear();
    end

    function automatic int elem(input int idx, input int n);
        return (idx < n) ? idx + 1 : idx - n + 1;
    endfunction

    // cut_kind: 0 full run, 1 abort at transfer cut_at, 2 stop feeding at cut_at.
    // mode: 0 in_valid steady, 1 in_valid toggles and start/size 0 held during the run.
    task automatic run_op(input int n, input int mode, input int cut_at, input int cut_kind);
        int  tot, idx, cnt, budget, d0, w;
        bit  take;
        tot = n + n * n; idx = 0; cnt = 0; budget = 4 * tot + 20;
        d0 = mon_dones;
        tif.start = 1'b1; tif.matrix_size = 8'(n);
        @(posedge clk); #1;
        tif.start = 1'b0;
        while (idx < tot && cnt < budget) begin
            if (cut_kind == 2 && idx == cut_at) break;
            tif.in_valid = (mode == 1) ? (cnt % 2 == 0) : 1'b1;
            tif.in_data  = 8'(elem(idx, n));
            tif.abort    = (cut_kind == 1 && idx == cut_at && tif.in_valid);
            if (mode == 1) begin
                tif.start = 1'b1; tif.matrix_size = 8'd0;
            end
            @(negedge clk);
            take = tif.in_valid && tif.in_ready;
            @(posedge clk); #1;
            cnt++;
            if (take) idx++;
            if (tif.abort) begin
                tif.abort = 1'b0;
                break;
            end
        end
        tif.in_valid = 1'b0; tif.start = 1'b0; tif.abort = 1'b0; tif.matrix_size = 8'd0;
        if (cut_kind == 0) begin
            check("op_transfers_fed", 32'(idx), 32'(tot));
            w = 0;
            while (mon_dones == d0 && w < 3 * n + 10) begin
                @(posedge clk); #1;
                w++;
            end
            check("op_done_seen", 32'(mon_dones - d0), 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int x0, p0, d0, e0, r0, exp_row;
        total = 0; bad = 0;
        reset = 1'b0;
        tif.start = 1'b0; tif.matrix_size = '0; tif.abort = 1'b0;
        tif.in_valid = 1'b0; tif.in_data = '0;
        acc = 0; mon_xfers = 0; mon_pushes = 0; mon_dones = 0; mon_errs = 0;
        cyc = 0; last_push_cyc = 0; last_done_cyc = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(tif.busy), 0);
        check("reset_in_ready", 32'(tif.in_ready), 0);
        check("reset_done", 32'(tif.done), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // N=3, steady stream: 12 transfers, results 14/32/50, done right after third push.
        x0 = mon_xfers; p0 = mon_pushes; d0 = mon_dones; r0 = res_q.size();
        run_op(3, 0, 0, 0);
        check("n3_xfers", 32'(mon_xfers - x0), 12);
        check("n3_pushes", 32'(mon_pushes - p0), 3);
        check("n3_dones", 32'(mon_dones - d0), 1);
        check("n3_done_after_push", 32'(last_done_cyc - last_push_cyc), 1);
        check("n3_res0", 32'(res_q[r0]), 14);
        check("n3_res1", 32'(res_q[r0 + 1]), 32);
        check("n3_res2", 32'(res_q[r0 + 2]), 50);

        // N=2, in_valid toggling, start with size 0 held mid-operation (must be ignored).
        x0 = mon_xfers; p0 = mon_pushes; d0 = mon_dones; e0 = mon_errs; r0 = res_q.size();
        run_op(2, 1, 0, 0);
        check("n2_xfers", 32'(mon_xfers - x0), 6);
        check("n2_pushes", 32'(mon_pushes - p0), 2);
        check("n2_dones", 32'(mon_dones - d0), 1);
        check("n2_no_err", 32'(mon_errs - e0), 0);
        check("n2_res0", 32'(res_q[r0]), 5);
        check("n2_res1", 32'(res_q[r0 + 1]), 11);

        // Rejected sizes 0 and 9.
        e0 = mon_errs;
        tif.start = 1'b1; tif.matrix_size = 8'd0;
        @(posedge clk); #1;
        tif.start = 1'b0;
        check("err0_pulse", 32'(tif.size_err), 1);
        check("err0_busy", 32'(tif.busy), 0);
        @(posedge clk); #1;
        check("err0_pulse_end", 32'(tif.size_err), 0);
        tif.start = 1'b1; tif.matrix_size = 8'd9;
        @(posedge clk); #1;
        tif.start = 1'b0;
        check("err9_pulse", 32'(tif.size_err), 1);
        check("err9_busy", 32'(tif.busy), 0);
        @(posedge clk); #1;
        check("err_count", 32'(mon_errs - e0), 2);

        // Abort and start together in IDLE: abort wins.
        tif.start = 1'b1; tif.abort = 1'b1; tif.matrix_size = 8'd2;
        @(posedge clk); #1;
        tif.start = 1'b0; tif.abort = 1'b0;
        check("abort_start_busy", 32'(tif.busy), 0);
        check("abort_start_err", 32'(tif.size_err), 0);

        // N=4, abort at row 1 col 2 (transfer index 10).
        x0 = mon_xfers; p0 = mon_pushes; d0 = mon_dones;
        run_op(4, 0, 10, 1);
        check("abort_busy", 32'(tif.busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_xfers", 32'(mon_xfers - x0), 10);
        check("abort_pushes", 32'(mon_pushes - p0), 1);
        check("abort_dones", 32'(mon_dones - d0), 0);

        // N=1 after the abort.
        x0 = mon_xfers; p0 = mon_pushes; d0 = mon_dones; r0 = res_q.size();
        run_op(1, 0, 0, 0);
        check("n1_xfers", 32'(mon_xfers - x0), 2);
        check("n1_pushes", 32'(mon_pushes - p0), 1);
        check("n1_dones", 32'(mon_dones - d0), 1);
        check("n1_res", 32'(res_q[r0]), 1);

        // Reset during LOAD_ROW of N=3, then a full fresh run.
        run_op(3, 0, 5, 2);
        check("pre_reset_busy", 32'(tif.busy), 1);
        reset = 1'b0;
        #1;
        check("async_rst_busy", 32'(tif.busy), 0);
        check("async_rst_in_ready", 32'(tif.in_ready), 0);
        check("async_rst_push", 32'(tif.result_push), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        x0 = mon_xfers; p0 = mon_pushes; d0 = mon_dones; r0 = res_q.size();
        run_op(3, 0, 0, 0);
        check("rst_n3_xfers", 32'(mon_xfers - x0), 12);
        check("rst_n3_pushes", 32'(mon_pushes - p0), 3);
        check("rst_n3_dones", 32'(mon_dones - d0), 1);
        check("rst_n3_res2", 32'(res_q[r0 + 2]), 50);

        // N=8: 72 transfers, 8 pushes; row r = sum_c (8r+c+1)(c+1).
        x0 = mon_xfers; p0 = mon_pushes; r0 = res_q.size();
        run_op(8, 0, 0, 0);
        check("n8_xfers", 32'(mon_xfers - x0), 72);
        check("n8_pushes", 32'(mon_pushes - p0), 8);
        check("n8_res0", 32'(res_q[r0]), 204);
        for (int r = 0; r < 8; r++) begin
            exp_row = 0;
            for (int c = 0; c < 8; c++) exp_row += (8 * r + c + 1) * (c + 1);
            check("n8_row", 32'(res_q[r0 + r]), 32'(exp_row));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
